// File: rtl/mmio_output_bank_pkg.sv
// Register map and field positions shared by the output bank and its users.
// Offsets are relative to the ADDRESS base of the register window.
package mmio_output_bank_pkg;

  localparam logic [31:0] OFS_DATA0    = 32'h00;
  localparam int          DATA_STRIDE  = 4;
  localparam logic [31:0] OFS_STATUS   = 32'h40;
  localparam logic [31:0] OFS_CONTROL  = 32'h44;
  localparam logic [31:0] OFS_IRQ_MASK = 32'h48;

  localparam int MAX_CHANNELS  = 8;

  localparam int STAT_NE_LSB   = 0;
  localparam int STAT_FULL_LSB = 8;
  localparam int STAT_PEND_LSB = 16;

  localparam int CTRL_FLUSH_BIT    = 0;
  localparam int CTRL_CLR_PEND_BIT = 1;

  function automatic logic [31:0] status_word(input logic [7:0] ne,
                                              input logic [7:0] full,
                                              input logic [7:0] pend);
    logic [31:0] w;
    w = '0;
    w[STAT_NE_LSB   +: MAX_CHANNELS] = ne;
    w[STAT_FULL_LSB +: MAX_CHANNELS] = full;
    w[STAT_PEND_LSB +: MAX_CHANNELS] = pend;
    return w;
  endfunction

endpackage

// File: rtl/mmio_output_bank_sync_fifo.sv
// Single-clock FIFO, state on falling edge; head visible combinationally, reads 0 when empty.
// Push into a full FIFO is accepted only if a pop happens in the same cycle, else flagged as overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_push_ok,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_pop_ok   = i_pop && !o_empty;
  assign o_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_overflow = i_push && o_full && !w_pop_ok;
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(negedge i_clk) begin
    if (!i_rst && !i_flush && o_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(negedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({o_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_output_bank.sv
// Memory-mapped bank of CHANNELS output FIFOs with status/control/irq registers.
// Bus reads are zero-latency; writes land on the falling edge; full channels drop data and raise pending.
module mmio_output_bank
  import mmio_output_bank_pkg::*;
#(
  parameter int          CHANNELS = 4,
  parameter int          WIDTH    = 8,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] ADDRESS  = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               data_address,
  inout  wire  [31:0]               data_bus,
  input  logic                      data_cs,
  input  logic                      data_rw,
  input  logic [1:0]                data_mode,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       value_valid,
  input  logic [CHANNELS-1:0]       value_ready,
  output logic                      interrupt,
  output logic                      write_pulse
);

  logic [31:0]         w_offset;
  logic                w_is_data;
  logic                w_is_status;
  logic                w_is_control;
  logic                w_is_mask;
  logic                w_hit;
  logic                w_wr;
  logic                w_rd;
  logic [2:0]          w_data_ch;
  logic                w_flush;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_push_ok;
  logic [CHANNELS-1:0] w_overflow;
  logic [CHANNELS-1:0] w_empty;
  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_pend_nxt;
  logic [31:0]         w_rd_dat;
  logic                w_unused;

  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_irq_mask;
  logic                r_write_pulse;

  assign w_offset     = data_address - ADDRESS;
  assign w_is_data    = (w_offset[1:0] == 2'b00) &&
                        (w_offset < 32'(DATA_STRIDE * CHANNELS));
  assign w_is_status  = (w_offset == OFS_STATUS);
  assign w_is_control = (w_offset == OFS_CONTROL);
  assign w_is_mask    = (w_offset == OFS_IRQ_MASK);
  assign w_data_ch    = w_offset[4:2];

  assign w_hit = data_cs && (w_is_data || w_is_status || w_is_control || w_is_mask);
  assign w_wr  = w_hit && data_rw;
  assign w_rd  = w_hit && !data_rw;

  assign w_flush = w_wr && w_is_control && data_bus[CTRL_FLUSH_BIT];

  // Access size is irrelevant: only the low bits of the bus carry channel data.
  assign w_unused = ^{data_mode, data_bus};

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_push[k] = w_wr && w_is_data && (w_data_ch == 3'(k));

    sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_flush    (w_flush),
      .i_push     (w_push[k]),
      .i_push_dat (data_bus[WIDTH-1:0]),
      .i_pop      (value_ready[k]),
      .o_head_dat (value[k*WIDTH +: WIDTH]),
      .o_empty    (w_empty[k]),
      .o_full     (w_full[k]),
      .o_push_ok  (w_push_ok[k]),
      .o_overflow (w_overflow[k])
    );
  end

  assign value_valid = ~w_empty;

  // Overflow is applied last so it survives a clear in the same cycle.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr && w_is_control && data_bus[CTRL_CLR_PEND_BIT]) begin
      w_pend_nxt = '0;
    end
    if (w_wr && w_is_status) begin
      w_pend_nxt = w_pend_nxt & ~data_bus[STAT_PEND_LSB +: CHANNELS];
    end
    w_pend_nxt = w_pend_nxt | w_overflow;
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_pend        <= '0;
      r_irq_mask    <= '0;
      r_write_pulse <= 1'b0;
    end else begin
      r_pend        <= w_pend_nxt;
      r_write_pulse <= |w_push_ok;
      if (w_wr && w_is_mask) begin
        r_irq_mask <= data_bus[CHANNELS-1:0];
      end
    end
  end

  assign interrupt   = |(r_pend & r_irq_mask);
  assign write_pulse = r_write_pulse;

  always_comb begin
    w_rd_dat = '0;
    if (w_is_status) begin
      w_rd_dat = status_word(8'(value_valid), 8'(w_full), 8'(r_pend));
    end else if (w_is_mask) begin
      w_rd_dat = 32'(r_irq_mask);
    end
  end

  assign data_bus = w_rd ? w_rd_dat : {32{1'bz}};

endmodule

// File: tb/tb_mmio_output_bank.sv
// Directed bench for mmio_output_bank: expected channel outputs are queued per channel
// and a concurrent monitor compares them whenever a channel handshake occurs.
module tb_mmio_output_bank;

  localparam int          CH   = 4;
  localparam int          W    = 8;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] A_D0 = BASE + 32'h00;
  localparam logic [31:0] A_D1 = BASE + 32'h04;
  localparam logic [31:0] A_D2 = BASE + 32'h08;
  localparam logic [31:0] A_ST = BASE + 32'h40;
  localparam logic [31:0] A_CT = BASE + 32'h44;
  localparam logic [31:0] A_MK = BASE + 32'h48;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   data_address;
  wire  [31:0]   data_bus;
  logic          data_cs;
  logic          data_rw;
  logic [1:0]    data_mode;
  logic [CH*W-1:0] value;
  logic [CH-1:0] value_valid;
  logic [CH-1:0] value_ready;
  logic          interrupt;
  logic          write_pulse;

  logic          tb_drv;
  logic [31:0]   tb_wdat;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q [CH][$];

  assign data_bus = tb_drv ? tb_wdat : {32{1'bz}};

  always #5 clk = ~clk;

  mmio_output_bank #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DEPTH    (4),
    .ADDRESS  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_address (data_address),
    .data_bus     (data_bus),
    .data_cs      (data_cs),
    .data_rw      (data_rw),
    .data_mode    (data_mode),
    .value        (value),
    .value_valid  (value_valid),
    .value_ready  (value_ready),
    .interrupt    (interrupt),
    .write_pulse  (write_pulse)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    data_cs      = 1'b0;
    data_rw      = 1'b0;
    data_address = 32'h0;
    data_mode    = 2'b10;
    tb_drv       = 1'b0;
    tb_wdat      = 32'h0;
  endtask

  // Inputs change just after the falling (active) edge; outputs are sampled on the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic exp_pulse, input string nm);
    data_cs = 1'b1; data_rw = 1'b1; data_address = a; tb_wdat = d; tb_drv = 1'b1;
    tick();
    idle();
    chk(nm, 32'(write_pulse), 32'(exp_pulse));
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    data_cs = 1'b1; data_rw = 1'b0; data_address = a; tb_drv = 1'b0;
    @(posedge clk);
    chk(nm, data_bus, exp);
    tick();
    idle();
  endtask

  task automatic clear_q();
    for (int k = 0; k < CH; k++) exp_q[k].delete();
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        for (int k = 0; k < CH; k++) begin
          if (value_valid[k] && value_ready[k]) begin
            n_checks++;
            if (exp_q[k].size() == 0) begin
              n_errors++;
              $display("FAIL pop_ch%0d: got %h, expected no output", k, value[k*W +: W]);
            end else begin
              e = exp_q[k].pop_front();
              if (value[k*W +: W] !== e) begin
                n_errors++;
                $display("FAIL pop_ch%0d: got %h, expected %h", k, value[k*W +: W], e);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    idle();
    value_ready = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_value", value, 32'h0);
    chk("rst_valid", 32'(value_valid), 32'h0);
    chk("rst_irq", 32'(interrupt), 32'h0);
    chk("rst_pulse", 32'(write_pulse), 32'h0);
    rst = 1'b0;
    rd_chk(A_ST, 32'h0, "status_after_rst");
    rd_chk(A_MK, 32'h0, "mask_after_rst");

    // Single write to channel 0.
    exp_q[0].push_back(8'h5A);
    wr(A_D0, 32'h5A, 1'b1, "pulse_d0");
    chk("d0_value", 32'(value[7:0]), 32'h5A);
    chk("d0_valid", 32'(value_valid), 32'h1);
    tick();
    chk("pulse_one_cycle", 32'(write_pulse), 32'h0);
    value_ready[0] = 1'b1;
    tick();
    value_ready[0] = 1'b0;
    chk("d0_drained_valid", 32'(value_valid), 32'h0);
    chk("d0_drained_value", value, 32'h0);

    // Fill channel 1 past capacity.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q[1].push_back(8'(i));
      wr(A_D1, 32'(i), (i <= 4), "pulse_d1_fill");
    end
    rd_chk(A_ST, 32'h0002_0202, "status_overflow");
    chk("irq_masked", 32'(interrupt), 32'h0);
    wr(A_MK, 32'h2, 1'b0, "pulse_mask_wr");
    chk("irq_unmasked", 32'(interrupt), 32'h1);
    rd_chk(A_MK, 32'h2, "mask_readback");

    // Push and pop together on a full FIFO.
    value_ready[1] = 1'b1;
    exp_q[1].push_back(8'h09);
    wr(A_D1, 32'h9, 1'b1, "pulse_push_pop_full");
    value_ready[1] = 1'b0;
    chk("head_after_push_pop", 32'(value[15:8]), 32'h2);
    rd_chk(A_ST, 32'h0002_0202, "status_push_pop_full");

    // Drain channel 1 on consecutive cycles.
    value_ready[1] = 1'b1;
    repeat (4) tick();
    value_ready[1] = 1'b0;
    chk("d1_valid_fell", 32'(value_valid[1]), 32'h0);
    chk("d1_all_emitted", 32'(exp_q[1].size()), 32'h0);

    // Clear pending by W1C.
    wr(A_ST, 32'h0002_0000, 1'b0, "pulse_w1c");
    rd_chk(A_ST, 32'h0, "status_after_w1c");
    chk("irq_after_w1c", 32'(interrupt), 32'h0);

    // Flush keeps pending and mask; clear-pending drops pending.
    for (int i = 0; i < 5; i++) begin
      wr(A_D1, 32'h11 + 32'(i), (i < 4), "pulse_d1_refill");
    end
    wr(A_D0, 32'h21, 1'b1, "pulse_d0_refill");
    rd_chk(A_ST, 32'h0002_0203, "status_before_flush");
    wr(A_CT, 32'h1, 1'b0, "pulse_flush");
    chk("flush_valid", 32'(value_valid), 32'h0);
    chk("flush_value", value, 32'h0);
    rd_chk(A_ST, 32'h0002_0000, "status_after_flush");
    chk("irq_after_flush", 32'(interrupt), 32'h1);
    wr(A_CT, 32'h2, 1'b0, "pulse_clr_pend");
    rd_chk(A_ST, 32'h0, "status_after_clr_pend");
    chk("irq_after_clr_pend", 32'(interrupt), 32'h0);

    // Push onto an empty FIFO while ready is already high.
    value_ready[2] = 1'b1;
    exp_q[2].push_back(8'h77);
    wr(A_D2, 32'h77, 1'b1, "pulse_d2_empty");
    chk("d2_valid_rose", 32'(value_valid), 32'h4);
    chk("d2_value", 32'(value[23:16]), 32'h77);
    tick();
    value_ready[2] = 1'b0;
    chk("d2_drained", 32'(value_valid), 32'h0);

    // Addresses outside the window or with chip select low are ignored.
    wr(BASE + 32'h10, 32'h55, 1'b0, "pulse_unmapped_ch4");
    wr(BASE + 32'h01, 32'h55, 1'b0, "pulse_misaligned");
    wr(32'h0, 32'h55, 1'b0, "pulse_below_base");
    data_cs = 1'b0; data_rw = 1'b1; data_address = A_D0; tb_wdat = 32'h55; tb_drv = 1'b1;
    tick();
    idle();
    chk("pulse_cs_low", 32'(write_pulse), 32'h0);
    chk("ignored_valid", 32'(value_valid), 32'h0);

    // Reset during a channel write.
    exp_q[0].push_back(8'h44);
    wr(A_D0, 32'h44, 1'b1, "pulse_pre_rst");
    for (int i = 0; i < 5; i++) begin
      wr(A_D1, 32'h30 + 32'(i), (i < 4), "pulse_pre_rst_fill");
    end
    chk("irq_pre_rst", 32'(interrupt), 32'h1);
    clear_q();
    data_cs = 1'b1; data_rw = 1'b1; data_address = A_D2; tb_wdat = 32'h33; tb_drv = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rst_mid_value", value, 32'h0);
    chk("rst_mid_valid", 32'(value_valid), 32'h0);
    chk("rst_mid_pulse", 32'(write_pulse), 32'h0);
    chk("rst_mid_irq", 32'(interrupt), 32'h0);
    rd_chk(A_ST, 32'h0, "status_after_mid_rst");
    rd_chk(A_MK, 32'h0, "mask_after_mid_rst");
    tick();
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
